// File: rtl/spi_link_bridge.sv
// Parallel-SPI bridge: pin deserialiser + RX FIFO toward the core,
// TX FIFO + burst serialiser toward the pins, with internal loopback.
module spi_link_bridge #(
   parameter int LANE_W    = 8,
   parameter int WORD_W    = 16,
   parameter int RX_DEPTH  = 256,
   parameter int TX_DEPTH  = 4,
   parameter int BIT_DUR   = 2,
   parameter int BURST_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_in,
   input  logic              sel_in,
   input  logic [LANE_W-1:0] data_in,
   output logic              rx_valid,
   output logic [WORD_W-1:0] rx_data,
   input  logic              rx_ready,
   input  logic              tx_valid,
   input  logic [WORD_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              clk_out,
   output logic              sel_out,
   output logic [LANE_W-1:0] data_out,
   input  logic              loopback,
   input  logic              clear_err,
   output logic              rx_overflow,
   output logic              frame_err,
   output logic [15:0]       drop_cnt
);
   localparam int BEATS = WORD_W / LANE_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW    = (BIT_DUR > 1) ? $clog2(BIT_DUR) : 1;
   localparam int SW    = $clog2(BURST_MAX + 1);
   localparam int RAW   = $clog2(RX_DEPTH);
   localparam int TAW   = $clog2(TX_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_TAIL, S_GAP} state_t;

   state_t            r_state, w_nxt;
   logic [TW-1:0]     r_tmr;
   logic [BW-1:0]     r_beat;
   logic [SW-1:0]     r_sent;
   logic [WORD_W-1:0] r_word;
   logic              r_mode;
   logic              w_tdone, w_load, w_new, w_shift;
   logic              w_ser_clk, w_ser_sel;
   logic [LANE_W-1:0] w_ser_data;

   logic [WORD_W-1:0] r_tx_mem [TX_DEPTH];
   logic [TAW:0]      r_tx_wr, r_tx_rd;
   logic              w_tx_empty, w_tx_full, w_tx_push;

   assign w_tx_empty = (r_tx_wr == r_tx_rd);
   assign w_tx_full  = (r_tx_wr[TAW] != r_tx_rd[TAW]) &&
                       (r_tx_wr[TAW-1:0] == r_tx_rd[TAW-1:0]);
   assign tx_ready   = ~w_tx_full & ~rst;
   assign w_tx_push  = tx_valid & tx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_wr <= '0;
         r_tx_rd <= '0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
         if (w_load)    r_tx_rd <= r_tx_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wr[TAW-1:0]] <= tx_data;
   end

   assign w_tdone = (r_tmr == TW'(BIT_DUR - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nxt;
   end

   always_comb begin
      w_nxt   = r_state;
      w_load  = 1'b0;
      w_new   = 1'b0;
      w_shift = 1'b0;
      unique case (r_state)
         S_IDLE: if (!w_tx_empty) begin
            w_nxt  = S_LOW;
            w_load = 1'b1;
            w_new  = 1'b1;
         end
         S_LOW: if (w_tdone) w_nxt = S_HIGH;
         S_HIGH: if (w_tdone) begin
            if (r_beat != BW'(BEATS - 1)) begin
               w_nxt   = S_LOW;
               w_shift = 1'b1;
            end else if (r_sent < SW'(BURST_MAX) && !w_tx_empty) begin
               w_nxt  = S_LOW;
               w_load = 1'b1;
            end else begin
               w_nxt = S_TAIL;
            end
         end
         S_TAIL: if (w_tdone) w_nxt = S_GAP;
         // A waiting word starts its burst straight after the gap so that
         // sel stays low for exactly BIT_DUR cycles between bursts.
         S_GAP: if (w_tdone) begin
            if (!w_tx_empty) begin
               w_nxt  = S_LOW;
               w_load = 1'b1;
               w_new  = 1'b1;
            end else begin
               w_nxt = S_IDLE;
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_ser_sel = 1'b0;
      w_ser_clk = 1'b0;
      unique case (r_state)
         S_LOW, S_TAIL: w_ser_sel = 1'b1;
         S_HIGH: begin
            w_ser_sel = 1'b1;
            w_ser_clk = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmr  <= '0;
         r_beat <= '0;
         r_sent <= '0;
         r_word <= '0;
         r_mode <= 1'b0;
      end else begin
         r_tmr <= (r_state == S_IDLE || w_nxt != r_state) ? '0 : r_tmr + 1'b1;
         if (w_load) begin
            r_word <= r_tx_mem[r_tx_rd[TAW-1:0]];
            r_beat <= '0;
            r_sent <= w_new ? SW'(1) : r_sent + 1'b1;
         end else if (w_shift) begin
            r_word <= r_word << LANE_W;
            r_beat <= r_beat + 1'b1;
         end
         if (w_new) r_mode <= loopback;
      end
   end

   assign w_ser_data = r_word[WORD_W-1 -: LANE_W];
   assign sel_out    = w_ser_sel & ~r_mode;
   assign clk_out    = w_ser_clk & ~r_mode;
   assign data_out   = r_mode ? '0 : w_ser_data;

   logic              w_src_clk, w_src_sel;
   logic [LANE_W-1:0] w_src_dat;
   logic              r_clk_s1, r_clk_s2, r_clk_d;
   logic              r_sel_s1, r_sel_s2, r_sel_d;
   logic [LANE_W-1:0] r_dat_s1, r_dat_s2;
   logic [BW-1:0]     r_rbeat;
   logic [WORD_W-1:0] r_rword, w_rword_nxt;
   logic              w_sample, w_fall, w_rlast, w_rpush, w_ferr_ev;

   assign w_src_clk = loopback ? w_ser_clk  : clk_in;
   assign w_src_sel = loopback ? w_ser_sel  : sel_in;
   assign w_src_dat = loopback ? w_ser_data : data_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         {r_clk_s1, r_clk_s2, r_clk_d} <= '0;
         {r_sel_s1, r_sel_s2, r_sel_d} <= '0;
         r_dat_s1 <= '0;
         r_dat_s2 <= '0;
      end else begin
         {r_clk_s1, r_clk_s2, r_clk_d} <= {w_src_clk, r_clk_s1, r_clk_s2};
         {r_sel_s1, r_sel_s2, r_sel_d} <= {w_src_sel, r_sel_s1, r_sel_s2};
         r_dat_s1 <= w_src_dat;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_sample    = r_clk_s2 & ~r_clk_d & r_sel_s2;
   assign w_fall      = r_sel_d & ~r_sel_s2;
   assign w_rword_nxt = (r_rword << LANE_W) | WORD_W'(r_dat_s2);
   assign w_rlast     = (r_rbeat == BW'(BEATS - 1));
   assign w_rpush     = w_sample & w_rlast;
   assign w_ferr_ev   = w_fall & (r_rbeat != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rbeat <= '0;
         r_rword <= '0;
      end else if (w_sample) begin
         r_rword <= w_rword_nxt;
         r_rbeat <= w_rlast ? '0 : r_rbeat + 1'b1;
      end else if (w_fall) begin
         r_rbeat <= '0;
      end
   end

   logic [WORD_W-1:0] r_rx_mem [RX_DEPTH];
   logic [RAW:0]      r_rx_wr, r_rx_rd;
   logic              w_rx_empty, w_rx_full, w_rx_wr_ok, w_drop, w_rx_pop;
   logic              r_ovf, r_ferr;
   logic [15:0]       r_drop;

   assign w_rx_empty = (r_rx_wr == r_rx_rd);
   assign w_rx_full  = (r_rx_wr[RAW] != r_rx_rd[RAW]) &&
                       (r_rx_wr[RAW-1:0] == r_rx_rd[RAW-1:0]);
   assign w_rx_wr_ok = w_rpush & ~w_rx_full;
   assign w_drop     = w_rpush & w_rx_full;
   assign rx_valid   = ~w_rx_empty;
   assign w_rx_pop   = rx_valid & rx_ready;
   assign rx_data    = rx_valid ? r_rx_mem[r_rx_rd[RAW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_wr <= '0;
         r_rx_rd <= '0;
      end else begin
         if (w_rx_wr_ok) r_rx_wr <= r_rx_wr + 1'b1;
         if (w_rx_pop)   r_rx_rd <= r_rx_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_rx_wr_ok) r_rx_mem[r_rx_wr[RAW-1:0]] <= w_rword_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf  <= 1'b0;
         r_ferr <= 1'b0;
         r_drop <= '0;
      end else begin
         r_ovf  <= w_drop | (r_ovf & ~clear_err);
         r_ferr <= w_ferr_ev | (r_ferr & ~clear_err);
         if (clear_err)
            r_drop <= {15'd0, w_drop};
         else if (w_drop && r_drop != 16'hFFFF)
            r_drop <= r_drop + 16'd1;
      end
   end

   assign rx_overflow = r_ovf;
   assign frame_err   = r_ferr;
   assign drop_cnt    = r_drop;
endmodule

// File: tb/tb_spi_link_bridge.sv
// Directed bench for spi_link_bridge: a default instance and one with
// a 4-deep RX FIFO and 2-word bursts share all stimulus.
module tb_spi_link_bridge;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, clk_in = 1'b0, sel_in = 1'b0;
   logic [7:0]  data_in = '0;
   logic        rx_ready = 1'b0, tx_valid = 1'b0;
   logic [15:0] tx_data = '0;
   logic        loopback = 1'b0, clear_err = 1'b0;

   logic        a_rx_valid, a_tx_ready, a_clk_out, a_sel_out;
   logic        a_rx_overflow, a_frame_err;
   logic [15:0] a_rx_data, a_drop_cnt;
   logic [7:0]  a_data_out;
   logic        b_rx_valid, b_tx_ready, b_clk_out, b_sel_out;
   logic        b_rx_overflow, b_frame_err;
   logic [15:0] b_rx_data, b_drop_cnt;
   logic [7:0]  b_data_out;

   int n_cmp = 0;
   int n_bad = 0;
   int runs[$];
   logic [7:0] edata[$];
   int estab[$];

   spi_link_bridge dA (
      .clk(clk), .rst(rst), .clk_in(clk_in), .sel_in(sel_in),
      .data_in(data_in), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
      .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(a_tx_ready), .clk_out(a_clk_out), .sel_out(a_sel_out),
      .data_out(a_data_out), .loopback(loopback), .clear_err(clear_err),
      .rx_overflow(a_rx_overflow), .frame_err(a_frame_err),
      .drop_cnt(a_drop_cnt)
   );

   spi_link_bridge #(.RX_DEPTH(4), .BURST_MAX(2)) dB (
      .clk(clk), .rst(rst), .clk_in(clk_in), .sel_in(sel_in),
      .data_in(data_in), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
      .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(b_tx_ready), .clk_out(b_clk_out), .sel_out(b_sel_out),
      .data_out(b_data_out), .loopback(loopback), .clear_err(clear_err),
      .rx_overflow(b_rx_overflow), .frame_err(b_frame_err),
      .drop_cnt(b_drop_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      clk_in = 0; sel_in = 0; data_in = '0; rx_ready = 0;
      tx_valid = 0; loopback = 0; clear_err = 0;
      rst = 1;
      repeat (2) tick;
      rst = 0;
      tick;
   endtask

   task automatic rx_beat(input logic [7:0] d);
      data_in = d;
      clk_in = 0;
      repeat (4) tick;
      clk_in = 1;
      repeat (4) tick;
   endtask

   task automatic rx_send(input logic [15:0] w);
      sel_in = 1;
      rx_beat(w[15:8]);
      rx_beat(w[7:0]);
      clk_in = 0;
      repeat (4) tick;
      sel_in = 0;
      repeat (6) tick;
   endtask

   task automatic tx_run(input int n, input logic [15:0] w0,
                         input logic [15:0] w1, input logic [15:0] w2,
                         input bit use_b);
      logic [15:0] ws [3];
      logic s, c, ps, pc;
      logic [7:0] d, ld;
      int run, drun;
      ws[0] = w0; ws[1] = w1; ws[2] = w2;
      runs.delete(); edata.delete(); estab.delete();
      ps = 0; pc = 0; ld = '0; run = 0; drun = 0;
      for (int i = 0; i < 70; i++) begin
         if (i < n) begin
            tx_valid = 1;
            tx_data  = ws[i];
         end else begin
            tx_valid = 0;
         end
         tick;
         s = use_b ? b_sel_out  : a_sel_out;
         c = use_b ? b_clk_out  : a_clk_out;
         d = use_b ? b_data_out : a_data_out;
         if (s != ps) begin
            runs.push_back(run);
            run = 1;
         end else begin
            run++;
         end
         if (d != ld) drun = 1;
         else         drun++;
         if (c && !pc) begin
            edata.push_back(d);
            estab.push_back(drun - 1);
         end
         ps = s; pc = c; ld = d;
      end
      runs.push_back(run);
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) tick;
      n_cmp++; if (a_tx_ready !== 1'b0) begin n_bad++;
         $display("FAIL rst_tx_ready_in_reset: got %b want 0", a_tx_ready); end
      n_cmp++; if ({a_sel_out, a_clk_out, a_data_out} !== 10'd0) begin n_bad++;
         $display("FAIL rst_pins: got %h want 0", {a_sel_out, a_clk_out, a_data_out}); end
      n_cmp++; if (a_rx_valid !== 1'b0) begin n_bad++;
         $display("FAIL rst_rx_valid: got %b want 0", a_rx_valid); end
      rst = 0;
      tick;
      n_cmp++; if (a_tx_ready !== 1'b1) begin n_bad++;
         $display("FAIL rst_tx_ready_after: got %b want 1", a_tx_ready); end
      n_cmp++; if (b_tx_ready !== 1'b1) begin n_bad++;
         $display("FAIL rst_b_tx_ready_after: got %b want 1", b_tx_ready); end
      n_cmp++; if ({a_rx_overflow, a_frame_err, a_drop_cnt} !== 18'd0) begin n_bad++;
         $display("FAIL rst_errors: got %h want 0", {a_rx_overflow, a_frame_err, a_drop_cnt}); end
      n_cmp++; if (a_rx_data !== 16'h0) begin n_bad++;
         $display("FAIL rst_rx_data: got %h want 0", a_rx_data); end
   endtask

   task automatic test_single_rx;
      do_reset;
      rx_send(16'hABCD);
      n_cmp++; if (a_rx_valid !== 1'b1) begin n_bad++;
         $display("FAIL single_valid: got %b want 1", a_rx_valid); end
      n_cmp++; if (a_rx_data !== 16'hABCD) begin n_bad++;
         $display("FAIL single_data: got %h want abcd", a_rx_data); end
      n_cmp++; if ({a_rx_overflow, a_frame_err} !== 2'b00) begin n_bad++;
         $display("FAIL single_errors: got %b want 00", {a_rx_overflow, a_frame_err}); end
      rx_ready = 1;
      tick;
      rx_ready = 0;
      n_cmp++; if (a_rx_valid !== 1'b0) begin n_bad++;
         $display("FAIL single_only_one: got %b want 0", a_rx_valid); end
   endtask

   task automatic test_overflow;
      logic [15:0] exp_w;
      do_reset;
      for (int i = 0; i < 6; i++) rx_send(16'h1001 + 16'(i));
      n_cmp++; if (b_rx_overflow !== 1'b1) begin n_bad++;
         $display("FAIL ovf_flag: got %b want 1", b_rx_overflow); end
      n_cmp++; if (b_drop_cnt !== 16'd2) begin n_bad++;
         $display("FAIL ovf_drop_cnt: got %0d want 2", b_drop_cnt); end
      n_cmp++; if ({a_rx_overflow, a_drop_cnt} !== 17'd0) begin n_bad++;
         $display("FAIL ovf_deep_fifo: got %h want 0", {a_rx_overflow, a_drop_cnt}); end
      for (int i = 0; i < 4; i++) begin
         exp_w = 16'h1001 + 16'(i);
         n_cmp++; if (b_rx_valid !== 1'b1 || b_rx_data !== exp_w) begin n_bad++;
            $display("FAIL ovf_word%0d: got %b/%h want 1/%h", i, b_rx_valid, b_rx_data, exp_w); end
         rx_ready = 1;
         tick;
         rx_ready = 0;
      end
      n_cmp++; if (b_rx_valid !== 1'b0) begin n_bad++;
         $display("FAIL ovf_drained: got %b want 0", b_rx_valid); end
      clear_err = 1;
      tick;
      clear_err = 0;
      n_cmp++; if (b_rx_overflow !== 1'b0) begin n_bad++;
         $display("FAIL ovf_clear_flag: got %b want 0", b_rx_overflow); end
      n_cmp++; if (b_drop_cnt !== 16'd0) begin n_bad++;
         $display("FAIL ovf_clear_cnt: got %0d want 0", b_drop_cnt); end
   endtask

   task automatic test_frame_abort;
      do_reset;
      sel_in = 1;
      rx_beat(8'h11);
      clk_in = 0;
      repeat (4) tick;
      sel_in = 0;
      repeat (6) tick;
      n_cmp++; if (a_rx_valid !== 1'b0) begin n_bad++;
         $display("FAIL abort_no_push: got %b want 0", a_rx_valid); end
      n_cmp++; if (a_frame_err !== 1'b1) begin n_bad++;
         $display("FAIL abort_flag: got %b want 1", a_frame_err); end
      rx_send(16'h2233);
      n_cmp++; if (a_rx_valid !== 1'b1 || a_rx_data !== 16'h2233) begin n_bad++;
         $display("FAIL abort_next_word: got %b/%h want 1/2233", a_rx_valid, a_rx_data); end
      clear_err = 1;
      tick;
      clear_err = 0;
      n_cmp++; if (a_frame_err !== 1'b0) begin n_bad++;
         $display("FAIL abort_clear: got %b want 0", a_frame_err); end
   endtask

   task automatic test_tx_burst;
      logic [7:0] exp_d [4];
      logic [7:0] got;
      int st;
      exp_d[0] = 8'h12; exp_d[1] = 8'h34; exp_d[2] = 8'h56; exp_d[3] = 8'h78;
      do_reset;
      tx_run(2, 16'h1234, 16'h5678, 16'h0, 1'b0);
      n_cmp++; if (edata.size() != 4) begin n_bad++;
         $display("FAIL burst_edges: got %0d want 4", edata.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < edata.size()) ? edata[i] : 8'hxx;
         st  = (i < estab.size()) ? estab[i] : -1;
         n_cmp++; if (got !== exp_d[i]) begin n_bad++;
            $display("FAIL burst_lane%0d: got %h want %h", i, got, exp_d[i]); end
         n_cmp++; if (st < 2) begin n_bad++;
            $display("FAIL burst_setup%0d: got %0d cycles want >=2", i, st); end
      end
      n_cmp++; if (runs.size() != 3) begin n_bad++;
         $display("FAIL burst_sel_runs: got %0d want 3", runs.size()); end
      n_cmp++; if (runs.size() < 2 || runs[1] != 18) begin n_bad++;
         $display("FAIL burst_sel_high: got %0d want 18", (runs.size() > 1) ? runs[1] : -1); end
      n_cmp++; if (runs.size() < 3 || runs[2] < 2) begin n_bad++;
         $display("FAIL burst_sel_low: got %0d want >=2", (runs.size() > 2) ? runs[2] : -1); end
   endtask

   task automatic test_burst_limit;
      do_reset;
      tx_run(3, 16'hA1A2, 16'hB1B2, 16'hC1C2, 1'b1);
      n_cmp++; if (runs.size() != 5) begin n_bad++;
         $display("FAIL limit_runs: got %0d want 5", runs.size()); end
      n_cmp++; if (runs.size() < 2 || runs[1] != 18) begin n_bad++;
         $display("FAIL limit_first_high: got %0d want 18", (runs.size() > 1) ? runs[1] : -1); end
      n_cmp++; if (runs.size() < 3 || runs[2] != 2) begin n_bad++;
         $display("FAIL limit_gap: got %0d want 2", (runs.size() > 2) ? runs[2] : -1); end
      n_cmp++; if (runs.size() < 4 || runs[3] != 10) begin n_bad++;
         $display("FAIL limit_second_high: got %0d want 10", (runs.size() > 3) ? runs[3] : -1); end
      n_cmp++; if (edata.size() != 6 || edata[4] !== 8'hC1) begin n_bad++;
         $display("FAIL limit_third_word: got %0d edges want 6 with c1", edata.size()); end
   endtask

   task automatic test_loopback_reset;
      int pin_bad, seen, hi;
      do_reset;
      loopback = 1;
      tx_valid = 1;
      tx_data  = 16'hBEEF;
      tick;
      tx_valid = 0;
      pin_bad = 0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (a_sel_out || a_clk_out || a_data_out != 8'h0) pin_bad++;
         if (a_rx_valid) seen = 1;
      end
      n_cmp++; if (seen != 1) begin n_bad++;
         $display("FAIL loop_timeout: got %0d want 1", seen); end
      n_cmp++; if (a_rx_data !== 16'hBEEF) begin n_bad++;
         $display("FAIL loop_data: got %h want beef", a_rx_data); end
      n_cmp++; if (pin_bad != 0) begin n_bad++;
         $display("FAIL loop_pins_quiet: got %0d active cycles want 0", pin_bad); end
      loopback = 0;
      tx_valid = 1;
      tx_data  = 16'h1357;
      tick;
      tx_valid = 0;
      repeat (4) tick;
      n_cmp++; if (a_sel_out !== 1'b1) begin n_bad++;
         $display("FAIL midburst_sel: got %b want 1", a_sel_out); end
      rst = 1;
      tick;
      n_cmp++; if ({a_sel_out, a_clk_out, a_data_out} !== 10'd0) begin n_bad++;
         $display("FAIL midrst_pins: got %h want 0", {a_sel_out, a_clk_out, a_data_out}); end
      n_cmp++; if (a_rx_valid !== 1'b0 || a_rx_data !== 16'h0) begin n_bad++;
         $display("FAIL midrst_rx: got %b/%h want 0/0", a_rx_valid, a_rx_data); end
      n_cmp++; if (a_tx_ready !== 1'b0) begin n_bad++;
         $display("FAIL midrst_tx_ready: got %b want 0", a_tx_ready); end
      rst = 0;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (a_sel_out || a_rx_valid) hi++;
      end
      n_cmp++; if (hi != 0) begin n_bad++;
         $display("FAIL midrst_discard: got %0d active cycles want 0", hi); end
      n_cmp++; if (a_tx_ready !== 1'b1) begin n_bad++;
         $display("FAIL midrst_tx_ready_after: got %b want 1", a_tx_ready); end
   endtask

   initial begin
      test_reset;
      test_single_rx;
      test_overflow;
      test_frame_abort;
      test_tx_burst;
      test_burst_limit;
      test_loopback_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
